// File: rtl/add_serial_nb.sv
// Digit-serial adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, behind valid/ready handshakes.
// Optional feature: define ADD_SERIAL_SUB_EN to add the sub port (a - b computed as a + ~b + 1).
module add_serial_nb #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADD_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, and both sides hold until the transfer.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_out_valid;

    logic [DIGIT:0]   w_digit;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_c_msb;
    logic             w_last;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;

`ifdef ADD_SERIAL_SUB_EN
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    assign w_digit    = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
    assign w_sum_next = (r_sum >> DIGIT) | (WIDTH'(w_digit[DIGIT-1:0]) << (WIDTH - DIGIT));
    // The sum bit equals a ^ b ^ carry-in, so the carry into the top bit is recovered from it.
    assign w_c_msb    = w_digit[DIGIT-1] ^ r_a[DIGIT-1] ^ r_b[DIGIT-1];
    assign w_last     = (r_cnt == CW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= w_b_load;
                        r_carry <= w_c_load;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_digit[DIGIT];
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_cout      <= w_digit[DIGIT];
                        r_ovf       <= w_c_msb ^ w_digit[DIGIT];
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_add_serial_nb.sv
// Bench for add_serial_nb: three instances (DIGIT=1,4,8) share stimulus and are checked against an arithmetic model.
module tb_add_serial_nb;

  localparam int NI = 3;
  localparam int DIG[NI] = '{1, 4, 8};
`ifdef ADD_SERIAL_SUB_EN
  localparam bit SUB_ON = 1'b1;
`else
  localparam bit SUB_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic cin = 1'b0;
  logic sub_i = 1'b0;

  logic [NI-1:0] in_rdy;
  logic [NI-1:0] out_vld;
  logic [NI-1:0] cout_o;
  logic [NI-1:0] ovf_o;
  logic [7:0] sum_o[NI];
  logic [1:0] dbg_o[NI];

  int errors = 0;
  int checks = 0;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  add_serial_nb #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[0]),
    .a(a), .b(b), .cin(cin),
`ifdef ADD_SERIAL_SUB_EN
    .sub(sub_i),
`endif
    .out_valid(out_vld[0]), .out_ready(out_ready),
    .sum(sum_o[0]), .cout(cout_o[0]), .ovf(ovf_o[0]), .dbg_state(dbg_o[0]));

  add_serial_nb #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[1]),
    .a(a), .b(b), .cin(cin),
`ifdef ADD_SERIAL_SUB_EN
    .sub(sub_i),
`endif
    .out_valid(out_vld[1]), .out_ready(out_ready),
    .sum(sum_o[1]), .cout(cout_o[1]), .ovf(ovf_o[1]), .dbg_state(dbg_o[1]));

  add_serial_nb #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[2]),
    .a(a), .b(b), .cin(cin),
`ifdef ADD_SERIAL_SUB_EN
    .sub(sub_i),
`endif
    .out_valid(out_vld[2]), .out_ready(out_ready),
    .sum(sum_o[2]), .cout(cout_o[2]), .ovf(ovf_o[2]), .dbg_state(dbg_o[2]));

  // scoreboard
  logic [9:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic c, input logic s);
    int sx, sy, sres;
    int unsigned tot;
    logic [7:0] r;
    logic co, ov;
    sx = (x > 127) ? int'(x) - 256 : int'(x);
    sy = (y > 127) ? int'(y) - 256 : int'(y);
    if (s) begin
      r    = 8'(x - y);
      co   = (x >= y);
      sres = sx - sy;
    end else begin
      tot  = x + y + c;
      r    = 8'(tot);
      co   = (tot >= 256);
      sres = sx + sy + int'(c);
    end
    ov = (sres > 127) || (sres < -128);
    return {ov, co, r};
  endfunction

  // driver: one operation on all instances, optional DONE backpressure
  task automatic do_op(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                       input logic si, input int hold);
    logic [9:0] expv;
    int lat[NI];
    bit all_seen;
    exp_q.push_back(model(ai, bi, ci, si & SUB_ON));
    @(negedge clk);
    for (int i = 0; i < NI; i++) chk($sformatf("in_ready_idle_d%0d", DIG[i]), in_rdy[i], 1);
    a = ai; b = bi; cin = ci; sub_i = si; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub_i = 1'($urandom);
    for (int i = 0; i < NI; i++) lat[i] = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      all_seen = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (lat[i] == 0 && out_vld[i]) lat[i] = k;
        if (lat[i] == 0) all_seen = 1'b0;
      end
      if (all_seen) break;
    end
    expv = exp_q.pop_front();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("latency_d%0d", DIG[i]), lat[i], 8 / DIG[i]);
      chk($sformatf("sum_d%0d", DIG[i]), sum_o[i], expv[7:0]);
      chk($sformatf("cout_d%0d", DIG[i]), cout_o[i], expv[8]);
      chk($sformatf("ovf_d%0d", DIG[i]), ovf_o[i], expv[9]);
    end
    for (int h = 0; h < hold; h++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("hold_sum_d%0d", DIG[i]), sum_o[i], expv[7:0]);
        chk($sformatf("hold_cout_d%0d", DIG[i]), cout_o[i], expv[8]);
        chk($sformatf("hold_ovf_d%0d", DIG[i]), ovf_o[i], expv[9]);
        chk($sformatf("hold_in_ready_d%0d", DIG[i]), in_rdy[i], 0);
        chk($sformatf("hold_out_valid_d%0d", DIG[i]), out_vld[i], 1);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("released_out_valid_d%0d", DIG[i]), out_vld[i], 0);
      chk($sformatf("released_in_ready_d%0d", DIG[i]), in_rdy[i], 1);
    end
  endtask

  initial begin
    int vcount;
    // reset state
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_in_ready_d%0d", DIG[i]), in_rdy[i], 0);
      chk($sformatf("rst_out_valid_d%0d", DIG[i]), out_vld[i], 0);
      chk($sformatf("rst_sum_d%0d", DIG[i]), sum_o[i], 0);
      chk($sformatf("rst_cout_d%0d", DIG[i]), cout_o[i], 0);
      chk($sformatf("rst_ovf_d%0d", DIG[i]), ovf_o[i], 0);
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) chk($sformatf("post_rst_in_ready_d%0d", DIG[i]), in_rdy[i], 1);

    // directed vectors
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, 0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    do_op(8'h00, 8'h00, 1'b1, 1'b0, 0);
    do_op(8'h9C, 8'hA5, 1'b1, 1'b0, 0);
    do_op(8'h80, 8'h80, 1'b0, 1'b0, 0);
    // backpressure in DONE
    do_op(8'h5A, 8'h3C, 1'b1, 1'b0, 5);

    // reset at step 3 of the DIGIT=1 run
    @(negedge clk);
    a = 8'hC3; b = 8'h7E; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("midrun_rst_in_ready_d%0d", DIG[i]), in_rdy[i], 0);
      chk($sformatf("midrun_rst_out_valid_d%0d", DIG[i]), out_vld[i], 0);
      chk($sformatf("midrun_rst_sum_d%0d", DIG[i]), sum_o[i], 0);
      chk($sformatf("midrun_rst_cout_d%0d", DIG[i]), cout_o[i], 0);
      chk($sformatf("midrun_rst_ovf_d%0d", DIG[i]), ovf_o[i], 0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) chk($sformatf("midrun_release_in_ready_d%0d", DIG[i]), in_rdy[i], 1);
    vcount = 0;
    out_ready = 1'b0;
    repeat (12) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) if (out_vld[i]) vcount++;
    end
    chk("no_out_valid_after_reset", vcount, 0);
    do_op(8'h10, 8'h20, 1'b0, 1'b0, 0);

`ifdef ADD_SERIAL_SUB_EN
    do_op(8'h05, 8'h07, 1'b0, 1'b1, 0);
    do_op(8'h80, 8'h01, 1'b1, 1'b1, 0);
    do_op(8'h33, 8'h33, 1'b0, 1'b1, 0);
`endif

    // random operations
    for (int n = 0; n < 16; n++)
      do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2));

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
